// File: rtl/flop_pipe_pkg.sv
// Shared helpers and constants for the flop_pipe elastic register slice.
// FLOP_PIPE_STATS_EN adds a saturating output-transfer counter to the top.
package flop_pipe_pkg;

  localparam int STATS_W = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flop_pipe_stage.sv
// One elastic stage: valid bit plus data word, loaded on advance, cleared by flush.
module flop_pipe_stage
  import flop_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             vld_d,
  input  logic [WIDTH-1:0] data_d,
  output logic             vld_q,
  output logic [WIDTH-1:0] data_q
);

  // Bubbles never overwrite data; flush drops validity but keeps the word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (clr) begin
      vld_q <= 1'b0;
    end else if (en) begin
      vld_q <= vld_d;
      if (vld_d) data_q <= data_d;
    end
  end

endmodule

// File: rtl/flop_pipe.sv
// Parametrised valid/ready register pipeline with bubble collapsing, flush and occupancy.
// Define FLOP_PIPE_STATS_EN to add the saturating xfer_cnt output.
module flop_pipe
  import flop_pipe_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [cnt_w(DEPTH)-1:0]  count
`ifdef FLOP_PIPE_STATS_EN
  ,
  output logic [STATS_W-1:0]       xfer_cnt
`endif
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] vld_src;
  logic [DEPTH-1:0] valid_nxt;
  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] data_src [DEPTH];
  logic [CW-1:0]    cnt_nxt;

  // A stage may advance if the stage below it advances or it holds a bubble.
  always_comb begin : adv_chain
    logic a;
    a   = out_ready | ~valid_q[DEPTH-1];
    adv = '0;
    adv[DEPTH-1] = a;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      a      = a | ~valid_q[i];
      adv[i] = a;
    end
  end

  assign in_ready  = adv[0] & ~flush & reset_n;
  assign out_valid = valid_q[DEPTH-1] & ~flush;
  assign out_data  = data_q[DEPTH-1];

  always_comb begin
    vld_src     = '0;
    vld_src[0]  = in_valid & in_ready;
    data_src[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_src[i]  = valid_q[i-1];
      data_src[i] = data_q[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    flop_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (flush),
      .en     (adv[g]),
      .vld_d  (vld_src[g]),
      .data_d (data_src[g]),
      .vld_q  (valid_q[g]),
      .data_q (data_q[g])
    );
  end

  // Occupancy is registered from the next-state valids so it tracks the stages exactly.
  always_comb begin
    valid_nxt = '0;
    cnt_nxt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_nxt[i] = flush ? 1'b0 : (adv[i] ? vld_src[i] : valid_q[i]);
      cnt_nxt      = cnt_nxt + CW'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else          count <= cnt_nxt;
  end

`ifdef FLOP_PIPE_STATS_EN
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

  // Flush does not clear the statistic; only reset does.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    xfer_cnt <= '0;
    else if (out_valid && out_ready) xfer_cnt <= sat_inc(xfer_cnt);
  end
`endif

endmodule

// File: tb/tb_flop_pipe.sv
// Self-checking bench for flop_pipe (WIDTH=4, DEPTH=3): vector table plus scoreboard.
module tb_flop_pipe;
  import flop_pipe_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 3;
  localparam int CW    = cnt_w(DEPTH);

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b0;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
`ifdef FLOP_PIPE_STATS_EN
  logic [STATS_W-1:0] xfer_cnt;
`endif

  flop_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
`ifdef FLOP_PIPE_STATS_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;
  logic [WIDTH-1:0] sb [$];

  typedef struct packed {
    logic       iv;
    logic [3:0] d;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [3:0] od;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else             npass++;
  endtask

  task automatic drive(input logic iv, input logic [3:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Scoreboard: accepted words are queued, delivered words must match in order.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          nchk++;
          $display("FAIL sb_underflow: got word %0h, expected no delivery", out_data);
        end else begin
          chk("sb_data", 32'(out_data), 32'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    // streaming, out_ready=1
    tbl[0]  = '{1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0};
    tbl[1]  = '{1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0, 2'd1};
    tbl[2]  = '{1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 4'h0, 2'd2};
    tbl[3]  = '{1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 4'h1, 2'd3};
    tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hA, 2'd3};
    tbl[5]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hC, 2'd2};
    tbl[6]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hF, 2'd1};
    tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0};
    // backpressure: five offered, three accepted, then drain
    tbl[8]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0};
    tbl[9]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 2'd1};
    tbl[10] = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 4'h0, 2'd2};
    tbl[11] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 4'h2, 2'd3};
    tbl[12] = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'h2, 2'd3};
    tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h2, 2'd3};
    tbl[14] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h3, 2'd2};
    tbl[15] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h4, 2'd1};
    tbl[16] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_count", i),     32'(count),     32'(tbl[i].cnt));
      if (tbl[i].ov) chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
    end
    chk("table_sb_drained", 32'(sb.size()), 32'd0);

    // bubble collapse: 7 parked in the last stage, 3 slides down behind it
    drive(1'b1, 4'h7, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bub_park_count", 32'(count),    32'd1);
    chk("bub_park_data",  32'(out_data), 32'h7);
    drive(1'b1, 4'h3, 1'b0, 1'b0);
    @(negedge clk);
    chk("bub_in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bub_count2", 32'(count),    32'd2);
    chk("bub_hold7",  32'(out_data), 32'h7);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bub_count2b", 32'(count), 32'd2);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bub_next_valid", 32'(out_valid), 32'd1);
    chk("bub_next_data",  32'(out_data),  32'h3);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bub_empty", 32'(count), 32'd0);

    // flush of a full pipe with both sides requesting
    drive(1'b1, 4'h8, 1'b0, 1'b0);
    drive(1'b1, 4'h9, 1'b0, 1'b0);
    drive(1'b1, 4'hB, 1'b0, 1'b0);
    drive(1'b1, 4'hD, 1'b1, 1'b1);
    @(negedge clk);
    chk("fl_count_full", 32'(count),     32'd3);
    chk("fl_in_ready",   32'(in_ready),  32'd0);
    chk("fl_out_valid",  32'(out_valid), 32'd0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_count0",    32'(count),     32'd0);
    chk("fl_ov_after",  32'(out_valid), 32'd0);
    sb.delete();
    drive(1'b1, 4'hE, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_lat1", 32'(out_valid), 32'd0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_lat2", 32'(out_valid), 32'd0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_lat3_valid", 32'(out_valid), 32'd1);
    chk("fl_lat3_data",  32'(out_data),  32'hE);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_alone", 32'(out_valid), 32'd0);
    chk("fl_sb_drained", 32'(sb.size()), 32'd0);

    // asynchronous reset mid-stream with two words held
    drive(1'b1, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ar_pre_count", 32'(count),    32'd2);
    chk("ar_pre_data",  32'(out_data), 32'h1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_data",  32'(out_data),  32'd0);
    chk("ar_count",     32'(count),     32'd0);
    chk("ar_in_ready",  32'(in_ready),  32'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ar_post_count", 32'(count), 32'd0);

`ifdef FLOP_PIPE_STATS_EN
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("st_rst", 32'(xfer_cnt), 32'd0);
    reset_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 5; i++) drive(1'b1, 4'(i), 1'b1, 1'b0);
    repeat (4) drive(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("st_five", 32'(xfer_cnt), 32'd5);
    for (int i = 0; i < 70000; i++) drive(1'b1, 4'(i), 1'b1, 1'b0);
    repeat (4) drive(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("st_sat", 32'(xfer_cnt), 32'hFFFF);
    repeat (3) drive(1'b1, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 4'h1, 1'b1, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("st_flush_keep", 32'(xfer_cnt), 32'hFFFF);
    sb.delete();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("st_reset_clear", 32'(xfer_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
